neuron_mac_unit: RTL and testbench

NEURON_MAC_UNIT -- requirements
Module: neuron_mac_unit

---
 rtl/neuron_mac_unit.sv | 106 ++++++++++
 tb/tb_neuron_mac_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_unit.sv
// Single-neuron multiply-accumulate engine: streams N_IN weight/activation pairs
// from two synchronous memories, adds a bias, saturates to Q8.8 and optionally applies ReLU.
module neuron_mac_unit #(
  parameter int N_IN   = 28,
  parameter int ADDR_W = 5,
  parameter int FRAC   = 8,
  parameter int RELU   = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [15:0]       BIAS,
  output logic [ADDR_W-1:0] ADDR,
  output logic              EN,
  output logic              WE,
  input  logic [15:0]       W_DO,
  input  logic [15:0]       X_DO,
  output logic              BUSY,
  output logic              DONE,
  output logic [15:0]       Y
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ACT  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(N_IN - 1);
  localparam logic signed [39:0] Q_MAX    = 40'sd32767;
  localparam logic signed [39:0] Q_MIN    = -40'sd32768;

  logic [1:0]          state;
  logic signed [39:0]  acc;
  logic signed [15:0]  bias_q;
  logic signed [31:0]  prod;
  logic signed [39:0]  shifted;
  logic signed [39:0]  sum;
  logic signed [15:0]  sat;
  logic [15:0]         result;

  assign WE   = 1'b0;
  assign prod = $signed(W_DO) * $signed(X_DO);

  // Arithmetic shift floors toward minus infinity, matching the Q8.8 truncation rule.
  always_comb begin
    shifted = acc >>> FRAC;
    sum     = shifted + 40'(bias_q);
    if (sum > Q_MAX)
      sat = 16'sh7FFF;
    else if (sum < Q_MIN)
      sat = 16'sh8000;
    else
      sat = sum[15:0];
    result = ((RELU != 0) && (sat < 0)) ? 16'h0000 : sat;
  end

  // NOTE: all state below is registered with non-blocking assignments so every
  // register samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      acc    <= '0;
      bias_q <= '0;
      ADDR   <= '0;
      EN     <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      Y      <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            state  <= S_RUN;
            acc    <= '0;
            bias_q <= BIAS;
            ADDR   <= '0;
            EN     <= 1'b1;
            BUSY   <= 1'b1;
          end
        end
        S_RUN: begin
          // Data for the index issued last cycle arrives on the falling edge in between.
          acc <= acc + 40'(prod);
          if (ADDR == LAST_IDX) begin
            EN    <= 1'b0;
            ADDR  <= '0;
            state <= S_ACT;
          end else begin
            ADDR <= ADDR + 1'b1;
          end
        end
        S_ACT: begin
          Y     <= result;
          DONE  <= 1'b1;
          state <= S_FIN;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Directed bench for neuron_mac_unit: one ReLU instance and one linear instance
// share stimulus and a negedge-returning memory model.
module tb_neuron_mac_unit;

  localparam int N_IN = 28;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] bias;
  logic [15:0] w_do;
  logic [15:0] x_do;

  logic [4:0]  addr,  addr_l;
  logic        en,    en_l;
  logic        we,    we_l;
  logic        busy,  busy_l;
  logic        done,  done_l;
  logic [15:0] y_r,   y_l;

  logic [15:0] wmem [N_IN];
  logic [15:0] xmem [N_IN];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  neuron_mac_unit #(.N_IN(N_IN), .ADDR_W(5), .FRAC(8), .RELU(1)) dut_r (
    .CLK(clk), .RST_N(rst_n), .START(start), .BIAS(bias),
    .ADDR(addr), .EN(en), .WE(we), .W_DO(w_do), .X_DO(x_do),
    .BUSY(busy), .DONE(done), .Y(y_r)
  );

  neuron_mac_unit #(.N_IN(N_IN), .ADDR_W(5), .FRAC(8), .RELU(0)) dut_l (
    .CLK(clk), .RST_N(rst_n), .START(start), .BIAS(bias),
    .ADDR(addr_l), .EN(en_l), .WE(we_l), .W_DO(w_do), .X_DO(x_do),
    .BUSY(busy_l), .DONE(done_l), .Y(y_l)
  );

  // Memories answer on the falling edge; garbage when not enabled exposes stray reads.
  always @(negedge clk) begin
    if (en) begin
      w_do <= wmem[addr];
      x_do <= xmem[addr];
    end else begin
      w_do <= 16'hDEAD;
      x_do <= 16'hBEEF;
    end
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] w, input logic [15:0] x);
    for (int i = 0; i < N_IN; i++) begin
      wmem[i] = w;
      xmem[i] = x;
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_addr"}, 40'(addr), 40'd0);
    check({tag, "_en"},   40'(en),   40'd0);
    check({tag, "_we"},   40'(we),   40'd0);
    check({tag, "_busy"}, 40'(busy), 40'd0);
    check({tag, "_done"}, 40'(done), 40'd0);
    check({tag, "_y"},    40'(y_r),  40'd0);
    check({tag, "_yl"},   40'(y_l),  40'd0);
  endtask

  // Caller is at a falling edge. mode 0: plain run, 1: extra STARTs sampled at E5/E20,
  // 2: reset sampled at E10. Ends at the falling edge following E30 (cycle after DONE).
  task automatic run(input string tag, input logic [15:0] b, input int mode);
    int done_cnt = 0;
    int done_at  = -1;
    int en_cnt   = 0;
    int addr_err = 0;
    int we_cnt   = 0;
    int busy_err = 0;
    bias  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bias  = 16'h5A5A;
    for (int n = 0; n <= 30; n++) begin
      if (n > 0) @(negedge clk);
      if (mode == 2 && n == 10) begin
        chk_reset({tag, "_rst"});
        check({tag, "_nodone"}, 40'(done_cnt), 40'd0);
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (en) begin
        if (int'(addr) != en_cnt) addr_err++;
        en_cnt++;
      end
      if (we || we_l) we_cnt++;
      if (busy !== (n <= 29)) busy_err++;
      if (done_l !== done) busy_err++;
      if (mode == 1) start = (n == 4 || n == 19);
      if (mode == 2 && n == 9) rst_n = 1'b0;
    end
    check({tag, "_done_at"}, 40'(done_at),  40'd29);
    check({tag, "_done_n"},  40'(done_cnt), 40'd1);
    check({tag, "_en_n"},    40'(en_cnt),   40'd28);
    check({tag, "_addr"},    40'(addr_err), 40'd0);
    check({tag, "_we"},      40'(we_cnt),   40'd0);
    check({tag, "_busy"},    40'(busy_err), 40'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    bias  = 16'h0000;
    load(16'h0100, 16'h0100);
    repeat (3) @(negedge clk);
    chk_reset("init");
    rst_n = 1'b1;
    @(negedge clk);

    // 28 * 1.0 * 1.0 = 28.0
    run("ones", 16'h0000, 0);
    check("ones_y",  40'(y_r), 40'h1C00);
    check("ones_yl", 40'(y_l), 40'h1C00);

    // 28 * 1.0 * -1.0 = -28.0
    @(negedge clk);
    load(16'h0100, 16'hFF00);
    run("neg", 16'h0000, 0);
    check("neg_y",  40'(y_r), 40'h0000);
    check("neg_yl", 40'(y_l), 40'hE400);

    // Huge positive sum saturates
    @(negedge clk);
    load(16'h7FFF, 16'h7FFF);
    run("psat", 16'h7FFF, 0);
    check("psat_y",  40'(y_r), 40'h7FFF);
    check("psat_yl", 40'(y_l), 40'h7FFF);

    // Back-to-back START in the cycle after DONE; accumulator must not carry over
    load(16'h0100, 16'h0100);
    run("b2b", 16'h0000, 0);
    check("b2b_y",  40'(y_r), 40'h1C00);
    check("b2b_yl", 40'(y_l), 40'h1C00);

    // Huge negative sum saturates
    @(negedge clk);
    load(16'h7FFF, 16'h8000);
    run("nsat", 16'h0000, 0);
    check("nsat_y",  40'(y_r), 40'h0000);
    check("nsat_yl", 40'(y_l), 40'h8000);

    // 0.5 * i/16 summed over i=0..27 = 11.8125, minus 0.5 bias = 11.3125 = 0x0B50
    @(negedge clk);
    for (int i = 0; i < N_IN; i++) begin
      wmem[i] = 16'h0080;
      xmem[i] = 16'(i * 16);
    end
    run("ramp", 16'hFF80, 0);
    check("ramp_y",  40'(y_r), 40'h0B50);
    check("ramp_yl", 40'(y_l), 40'h0B50);

    // Sum of raw -28 floors to -1 LSB after the shift
    @(negedge clk);
    load(16'h0001, 16'hFFFF);
    run("floor", 16'h0000, 0);
    check("floor_y",  40'(y_r), 40'h0000);
    check("floor_yl", 40'(y_l), 40'hFFFF);

    // Extra STARTs mid-run are ignored
    @(negedge clk);
    load(16'h0100, 16'h0100);
    run("restart", 16'h0000, 1);
    check("restart_y",  40'(y_r), 40'h1C00);
    check("restart_yl", 40'(y_l), 40'h1C00);

    // Reset mid-run abandons the evaluation; the next run is clean
    @(negedge clk);
    run("abort", 16'h0000, 2);
    @(negedge clk);
    run("after", 16'h0000, 0);
    check("after_y",  40'(y_r), 40'h1C00);
    check("after_yl", 40'(y_l), 40'h1C00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
